// File: rtl/pipe_skid_if.sv
// Valid/ready handshake bundle for one elastic pipeline stage.
// master: the environment side (drives the upstream offer and downstream accept).
// slave : the stage itself (accepts from upstream, presents to downstream).
interface pipe_skid_if #(
    parameter int DATA_W = 64
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with optional 2-entry skid buffer.
// With SKID_EN=1 in_ready comes straight from a flop, so no ready path crosses
// the stage; with SKID_EN=0 the stage is a single entry with pass-through ready.
// flush squashes held and same-cycle beats; stall_cnt counts back-pressured cycles.
module pipe_skid_reg #(
    parameter int                DATA_W    = 64,
    parameter bit                SKID_EN   = 1'b1,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_skid_if.slave       bus,
    input  logic             stall_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              in_ready_s;
    logic              acc_s;
    logic              rel_s;

    // Ready toward upstream: flopped when skidding, otherwise pass-through from downstream.
    assign in_ready_s = SKID_EN ? in_ready_q : (~out_valid_q | bus.out_ready);
    assign acc_s      = bus.in_valid & in_ready_s;
    assign rel_s      = out_valid_q & bus.out_ready;

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign stall_cnt     = stall_cnt_q;

    // Next-state, data-register and registered-handshake computation.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Squash everything; data registers intentionally keep their contents.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc_s) begin
                        main_d  = bus.in_data;
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (acc_s && rel_s) begin
                        main_d  = bus.in_data;
                        state_d = ST_FULL;
                    end else if (acc_s) begin
                        if (SKID_EN) begin
                            skid_d  = bus.in_data;
                            state_d = ST_SKID;
                        end else begin
                            // Unreachable without skid: ready implies release when full.
                            state_d = ST_FULL;
                        end
                    end else if (rel_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (rel_s) begin
                        main_d  = skid_q;
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_SKID;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_SKID);
    end

    // Saturating stall counter; clear wins over increment, flushed cycles are not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = {CNT_W{1'b0}};
        end else if (out_valid_q && !bus.out_ready && !flush && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, storage and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: one skid instance (CNT_W=3, non-zero reset value) and
// one single-entry instance. Accepted beats go into a FIFO model; a monitor pops
// and compares whenever the stage presents a beat.
module tb_pipe_skid_reg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       fl_a, clr_a, fl_b, clr_b;
    logic [2:0] sc_a;
    logic [3:0] sc_b;

    pipe_skid_if #(.DATA_W(16)) ifa ();
    pipe_skid_if #(.DATA_W(16)) ifb ();

    pipe_skid_reg #(.DATA_W(16), .SKID_EN(1'b1), .RESET_VAL(16'hBEEF), .CNT_W(3)) dut_a (
        .clk(clk), .rst(rst), .flush(fl_a), .bus(ifa), .stall_clr(clr_a), .stall_cnt(sc_a)
    );

    pipe_skid_reg #(.DATA_W(16), .SKID_EN(1'b0), .RESET_VAL(16'h0000), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .flush(fl_b), .bus(ifb), .stall_clr(clr_b), .stall_cnt(sc_b)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int          cnt_a = 0;
    int          cnt_b = 0;
    logic [15:0] seq_a = 16'h0100;
    logic [15:0] seq_b = 16'h0200;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor A: occupancy-derived handshake, counter model, in-order delivery.
    always @(negedge clk) begin
        if (!rst) begin
            chk("a_out_valid", 32'(ifa.out_valid), 32'(qa.size() > 0));
            chk("a_in_ready", 32'(ifa.in_ready), 32'(qa.size() < 2));
            chk("a_stall_cnt", 32'(sc_a), 32'(cnt_a));
            if (ifa.out_valid) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_beat", 32'(ifa.out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("a_out_data", 32'(ifa.out_data), 32'(qa[0]));
                    if (ifa.out_ready) void'(qa.pop_front());
                end
            end
            if (clr_a) cnt_a = 0;
            else if (dut_model_valid_a() && !ifa.out_ready && !fl_a && cnt_a < 7) cnt_a++;
        end
    end

    function automatic bit dut_model_valid_a();
        // Stall is judged on model occupancy before this cycle's release.
        return (qa.size() > 0) || (ifa.out_valid && ifa.out_ready && qa.size() >= 0 && 1'b0);
    endfunction

    // Monitor B: single entry, ready must equal ~valid | out_ready.
    always @(negedge clk) begin
        if (!rst) begin
            chk("b_out_valid", 32'(ifb.out_valid), 32'(qb.size() > 0));
            chk("b_in_ready", 32'(ifb.in_ready), 32'((qb.size() == 0) || ifb.out_ready));
            chk("b_stall_cnt", 32'(sc_b), 32'(cnt_b));
            if (clr_b) cnt_b = 0;
            else if (qb.size() > 0 && !ifb.out_ready && !fl_b && cnt_b < 15) cnt_b++;
            if (ifb.out_valid) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_beat", 32'(ifb.out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("b_out_data", 32'(ifb.out_data), 32'(qb[0]));
                    if (ifb.out_ready) void'(qb.pop_front());
                end
            end
        end
    end

    // Scoreboard feed: record accepted beats after the monitors have popped.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (fl_a) qa.delete();
            else if (ifa.in_valid && ifa.in_ready) qa.push_back(ifa.in_data);
            if (fl_b) qb.delete();
            else if (ifb.in_valid && ifb.in_ready) qb.push_back(ifb.in_data);
        end
    end

    task automatic step_a(input logic iv, input logic [15:0] d, input logic ordy,
                          input logic fl, input logic clr);
        @(posedge clk);
        #1;
        ifa.in_valid  = iv;
        ifa.in_data   = d;
        ifa.out_ready = ordy;
        fl_a          = fl;
        clr_a         = clr;
    endtask

    initial begin
        rst = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_data = 16'h0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = 16'h0; ifb.out_ready = 1'b0;
        fl_a = 1'b0; clr_a = 1'b0; fl_b = 1'b0; clr_b = 1'b0;
        #22;
        chk("rst_a_out_valid", 32'(ifa.out_valid), 32'd0);
        chk("rst_a_in_ready", 32'(ifa.in_ready), 32'd1);
        chk("rst_a_out_data", 32'(ifa.out_data), 32'hBEEF);
        chk("rst_a_stall_cnt", 32'(sc_a), 32'd0);
        chk("rst_b_out_data", 32'(ifb.out_data), 32'h0000);
        chk("rst_b_in_ready", 32'(ifb.in_ready), 32'd1);
        #1 rst = 1'b0;

        // Back-to-back stream with free downstream.
        step_a(1'b1, 16'h0011, 1'b1, 1'b0, 1'b0);
        step_a(1'b1, 16'h0022, 1'b1, 1'b0, 1'b0);
        step_a(1'b1, 16'h0033, 1'b1, 1'b0, 1'b0);
        step_a(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step_a(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Stall counting, saturation and clear.
        step_a(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
        repeat (5) step_a(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("stall_5", 32'(sc_a), 32'd5);
        repeat (5) step_a(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("stall_sat", 32'(sc_a), 32'd7);
        step_a(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #2;
        chk("stall_clr", 32'(sc_a), 32'd0);

        // Skid fill from FULL(0xA), then drain in order.
        step_a(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("skid_in_ready", 32'(ifa.in_ready), 32'd0);
        step_a(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step_a(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step_a(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("drain_in_ready", 32'(ifa.in_ready), 32'd1);

        // Flush while in SKID with a beat on offer.
        step_a(1'b1, 16'h00C0, 1'b0, 1'b0, 1'b0);
        step_a(1'b1, 16'h00D0, 1'b0, 1'b0, 1'b0);
        step_a(1'b1, 16'h00E0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #2;
        chk("flush_out_valid", 32'(ifa.out_valid), 32'd0);
        chk("flush_in_ready", 32'(ifa.in_ready), 32'd1);
        step_a(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step_a(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in SKID.
        step_a(1'b1, 16'h00F0, 1'b0, 1'b0, 1'b0);
        step_a(1'b1, 16'h00F1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        ifa.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(ifa.out_valid), 32'd0);
        chk("arst_out_data", 32'(ifa.out_data), 32'hBEEF);
        chk("arst_stall_cnt", 32'(sc_a), 32'd0);
        chk("arst_in_ready", 32'(ifa.in_ready), 32'd1);
        qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0;
        #1 rst = 1'b0;
        step_a(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step_a(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Random traffic on both instances with incrementing payloads.
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            ifa.in_valid  = ($urandom_range(0, 3) != 0);
            ifa.in_data   = seq_a;
            ifa.out_ready = $urandom_range(0, 1) != 0;
            fl_a          = ($urandom_range(0, 15) == 0);
            clr_a         = ($urandom_range(0, 31) == 0);
            ifb.in_valid  = $urandom_range(0, 1) != 0;
            ifb.in_data   = seq_b;
            ifb.out_ready = $urandom_range(0, 1) != 0;
            clr_b         = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            #2;
            if (ifa.in_valid && ifa.in_ready) seq_a++;
            if (ifb.in_valid && ifb.in_ready) seq_b++;
        end

        // Drain and finish.
        @(posedge clk); #1;
        ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
        ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
        fl_a = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("end_a_empty", 32'(qa.size()), 32'd0);
        chk("end_b_empty", 32'(qb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
